// File: rtl/noc_inject_pkg.sv
// Shared types and constants for the NoC flit-injection source.
package noc_inject_pkg;

  localparam int FLIT_W_DEFAULT = 20;
  localparam int STAT_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } inj_state_t;

endpackage

// File: rtl/noc_flit_inject_src_if.sv
// Flit stream from the injection source into a router local port.
interface noc_flit_inject_src_if
  import noc_inject_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEFAULT
);

  logic [FLIT_W-1:0] dataout;
  logic              out_valid;
  logic              out_ready;

  modport master (output dataout, output out_valid, input out_ready);
  modport slave  (input dataout, input out_valid, output out_ready);

endinterface

// File: rtl/noc_inject_mem.sv
// Pattern storage: synchronous write, asynchronous read.
module noc_inject_mem
   import noc_inject_pkg::*;
#(
   parameter int    FLIT_W    = FLIT_W_DEFAULT,
   parameter int    DEPTH     = 32,
   parameter int    ADDR_W    = $clog2(DEPTH),
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [FLIT_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [FLIT_W-1:0] o_rd_data
);

   logic [FLIT_W-1:0] r_mem [DEPTH];

   // Contents are not reset; cleared once at elaboration.
   initial begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
   end

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/noc_flit_inject_src.sv
// Programmable flit-injection source with burst, gap and repeat control.
// Define INJ_STATS_EN to add saturating sent/stall counters.
module noc_flit_inject_src
  import noc_inject_pkg::*;
#(
  parameter int    FLIT_W    = FLIT_W_DEFAULT,
  parameter int    DEPTH     = 32,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter int    GAP_W     = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [ADDR_W:0]   i_num_flits,
  input  logic [GAP_W-1:0]  i_gap,
  input  logic              i_repeat_mode,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [FLIT_W-1:0] i_wr_data,
  noc_flit_inject_src_if.master m_out,
  output logic              o_busy,
  output logic              o_done
`ifdef INJ_STATS_EN
  ,
  output logic [STAT_W-1:0] o_sent_cnt,
  output logic [STAT_W-1:0] o_stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SEND = SEND;
  localparam logic [1:0] S_GAP  = GAP;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_len;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gcnt;
  logic              r_rep;
  logic [FLIT_W-1:0] r_dataout;
  logic              r_valid;
  logic              r_done;

  logic              w_xfer;
  logic              w_last;
  logic              w_start;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W:0]   w_len_start;
  logic [FLIT_W-1:0] w_rd_data;

  assign w_xfer      = r_valid & m_out.out_ready;
  assign w_last      = ({1'b0, r_idx} == (r_len - (ADDR_W+1)'(1)));
  assign w_next      = w_last ? '0 : r_idx + ADDR_W'(1);
  assign w_start     = i_enable && (i_num_flits != '0);
  assign w_len_start = (i_num_flits > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : i_num_flits;
  assign w_wr_ok     = i_wr_en && !o_busy && ({1'b0, i_wr_addr} < (ADDR_W+1)'(DEPTH));

  // Single read port: address depends on which flit the next edge loads.
  always_comb begin
    w_rd_addr = r_idx;
    case (r_state)
      S_IDLE:  w_rd_addr = '0;
      S_SEND:  w_rd_addr = w_next;
      default: w_rd_addr = r_idx;
    endcase
  end

  noc_inject_mem #(
    .FLIT_W    (FLIT_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_gap     <= '0;
      r_gcnt    <= '0;
      r_rep     <= 1'b0;
      r_dataout <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len     <= w_len_start;
            r_gap     <= i_gap;
            r_rep     <= i_repeat_mode;
            r_idx     <= '0;
            r_dataout <= w_rd_data;
            r_valid   <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            // Abort only ever takes effect after the pending flit is accepted.
            if (!i_enable || (w_last && !r_rep)) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_gap == '0) begin
              r_dataout <= w_rd_data;
              r_idx     <= w_next;
            end else begin
              r_valid <= 1'b0;
              r_gcnt  <= r_gap;
              r_idx   <= w_next;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_gcnt <= r_gcnt - GAP_W'(1);
          if (!i_enable) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_gcnt == GAP_W'(1)) begin
            r_dataout <= w_rd_data;
            r_valid   <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_DONE: begin
          if (!i_enable) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_out.dataout   = r_dataout;
  assign m_out.out_valid = r_valid;
  assign o_busy          = (r_state == S_SEND) || (r_state == S_GAP);
  assign o_done          = r_done;

`ifdef INJ_STATS_EN
  logic [STAT_W-1:0] r_sent_cnt;
  logic [STAT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sent_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_sent_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_xfer && (r_sent_cnt != '1)) r_sent_cnt <= r_sent_cnt + STAT_W'(1);
      if (r_valid && !m_out.out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign o_sent_cnt  = r_sent_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_noc_flit_inject_src.sv
// Directed bench for noc_flit_inject_src with hand-computed expected flit streams.
module tb_noc_flit_inject_src;
  import noc_inject_pkg::*;

  localparam int FW    = 20;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int GW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [AW:0]   num_flits = '0;
  logic [GW-1:0] gap = '0;
  logic          repeat_mode = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [FW-1:0] wr_data = '0;
  logic          busy;
  logic          done;
`ifdef INJ_STATS_EN
  logic [15:0]   sent_cnt;
  logic [15:0]   stall_cnt;
`endif

  noc_flit_inject_src_if #(.FLIT_W(FW)) ifc ();

  noc_flit_inject_src #(
    .FLIT_W (FW),
    .DEPTH  (DEPTH),
    .GAP_W  (GW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (enable),
    .i_num_flits   (num_flits),
    .i_gap         (gap),
    .i_repeat_mode (repeat_mode),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .m_out         (ifc),
    .o_busy        (busy),
    .o_done        (done)
`ifdef INJ_STATS_EN
    ,
    .o_sent_cnt    (sent_cnt),
    .o_stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [FW-1:0] q[$];
  logic [63:0]   vtr;
  logic [FW-1:0] dtr[64];
  int            done_at;
  int            n_stall;
  logic          busy_at_done;

  task automatic wr(input logic [AW-1:0] a, input logic [FW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a burst, collects accepted flits until done or budget, then re-arms.
  task automatic run(input logic [AW:0] nf, input logic [GW-1:0] g, input logic rp,
                     input logic [63:0] rdy_lo, input int drop_at, input int budget,
                     input logic do_wr, input logic [AW-1:0] wa, input logic [FW-1:0] wd);
    int k;
    k = 0; q.delete(); vtr = '0; done_at = -1; n_stall = 0; busy_at_done = 1'b1;
    @(negedge clk);
    num_flits = nf; gap = g; repeat_mode = rp; enable = 1'b1;
    ifc.out_ready = !rdy_lo[0];
    wr_en = do_wr; wr_addr = wa; wr_data = wd;
    for (int i = 1; i < budget; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      ifc.out_ready = !rdy_lo[i];
      vtr[i] = ifc.out_valid;
      dtr[i] = ifc.dataout;
      if (done) begin
        done_at = i;
        busy_at_done = busy;
        break;
      end
      if (ifc.out_valid && !ifc.out_ready) n_stall++;
      if (ifc.out_valid && ifc.out_ready) begin
        q.push_back(ifc.dataout);
        k++;
        if (k == drop_at) enable = 1'b0;
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_data",  {12'b0, ifc.dataout}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    rst = 1'b1;

    wr(5'd0, 20'h20010);
    wr(5'd1, 20'h20020);
    wr(5'd2, 20'h21011);
    wr(5'd3, 20'h21021);
    wr(5'd31, 20'hABCDE);

    // back-to-back burst of 4
    run(6'd4, 4'd0, 1'b0, 64'h0, 0, 20, 1'b0, '0, '0);
    chk("t1_count", q.size(), 32'd4);
    chk("t1_f0", {12'b0, q[0]}, 32'h20010);
    chk("t1_f1", {12'b0, q[1]}, 32'h20020);
    chk("t1_f2", {12'b0, q[2]}, 32'h21011);
    chk("t1_f3", {12'b0, q[3]}, 32'h21021);
    chk("t1_valid", {26'b0, vtr[5:0]}, 32'b011110);
    chk("t1_done_at", done_at, 32'd5);
    chk("t1_busy_done", {31'b0, busy_at_done}, 32'd0);
    chk("t1_rearm", {31'b0, done}, 32'd0);

    // stall on cycles 2..4
    run(6'd4, 4'd0, 1'b0, 64'h1C, 0, 20, 1'b0, '0, '0);
    chk("t2_count", q.size(), 32'd4);
    chk("t2_f1", {12'b0, q[1]}, 32'h20020);
    chk("t2_f2", {12'b0, q[2]}, 32'h21011);
    chk("t2_hold2", {12'b0, dtr[2]}, 32'h20020);
    chk("t2_hold4", {12'b0, dtr[4]}, 32'h20020);
    chk("t2_stalls", n_stall, 32'd3);
    chk("t2_done_at", done_at, 32'd8);
`ifdef INJ_STATS_EN
    chk("t2_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    chk("t2_sent_cnt", {16'b0, sent_cnt}, 32'd4);
`endif

    // gap of 2 between 3 flits
    run(6'd3, 4'd2, 1'b0, 64'h0, 0, 20, 1'b0, '0, '0);
    chk("t3_valid", {25'b0, vtr[7:1]}, 32'b1001001);
    chk("t3_count", q.size(), 32'd3);
    chk("t3_f2", {12'b0, q[2]}, 32'h21011);
    chk("t3_done_at", done_at, 32'd8);

    // repeat mode, drop enable on the 7th transfer
    run(6'd2, 4'd0, 1'b1, 64'h0, 7, 30, 1'b0, '0, '0);
    chk("t4_count", q.size(), 32'd7);
    chk("t4_f5", {12'b0, q[5]}, 32'h20020);
    chk("t4_f6", {12'b0, q[6]}, 32'h20010);
    chk("t4_done_at", done_at, 32'd8);

    // zero-length request stays idle
    run(6'd0, 4'd0, 1'b0, 64'h0, 0, 6, 1'b0, '0, '0);
    chk("t5_count", q.size(), 32'd0);
    chk("t5_valid", vtr[31:0], 32'd0);
    chk("t5_no_done", done_at, 32'hFFFFFFFF);

    // over-length request clips to DEPTH
    run(6'd40, 4'd0, 1'b0, 64'h0, 0, 45, 1'b0, '0, '0);
    chk("t5_clip", q.size(), 32'd32);
    chk("t5_f4", {12'b0, q[4]}, 32'h0);
    chk("t5_f31", {12'b0, q[31]}, 32'hABCDE);
    chk("t5_done_at", done_at, 32'd33);

    // write while busy, then async reset mid-SEND
    @(negedge clk);
    num_flits = 6'd4; gap = '0; repeat_mode = 1'b0; enable = 1'b1; ifc.out_ready = 1'b0;
    @(negedge clk);
    chk("t6_busy", {31'b0, busy}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 20'hFFFFF;
    @(negedge clk);
    wr_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("t6_rst_data",  {12'b0, ifc.dataout}, 32'd0);
    chk("t6_rst_busy",  {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; ifc.out_ready = 1'b1;
    @(negedge clk);
    run(6'd1, 4'd0, 1'b0, 64'h0, 0, 10, 1'b0, '0, '0);
    chk("t6_restart", {12'b0, q[0]}, 32'h20010);

    // write and start on the same edge: first burst sees the old word
    run(6'd1, 4'd0, 1'b0, 64'h0, 0, 10, 1'b1, 5'd0, 20'h20099);
    chk("t7_old", {12'b0, q[0]}, 32'h20010);
    run(6'd1, 4'd0, 1'b0, 64'h0, 0, 10, 1'b0, '0, '0);
    chk("t7_new", {12'b0, q[0]}, 32'h20099);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
